// File: rtl/seq_trigger_conditioner.sv
// Trigger conditioner for the DC sequencer: converts a level crossing on a
// sample stream (with hysteresis) or a rising edge on the external trigger
// line into clean single-cycle step pulses, with holdoff, single-shot or
// auto-rearm operation, and a saturating trigger counter.
module seq_trigger_conditioner #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sig_in,
    input  logic              ext_trig,
    input  logic              src_sel,
    input  logic [DATA_W-1:0] level,
    input  logic [DATA_W-1:0] hyst,
    input  logic              edge_sel,
    input  logic              single,
    input  logic              arm,
    input  logic [CNT_W-1:0]  holdoff,
    input  logic              cnt_clr,
    output logic              trig_out,
    output logic              armed,
    output logic [CNT_W-1:0]  trig_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        READY   = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    // Two guard bits so that level -/+ an unsigned hyst of full width never wraps.
    localparam int EXT_W = DATA_W + 2;
    localparam logic signed [EXT_W-1:0] SAT_MAX = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {3'b111, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]        CNT_MAX = '1;

    state_t                    state_reg, state_next;
    logic [CNT_W-1:0]          hold_cnt_reg, hold_cnt_next;
    logic [CNT_W-1:0]          count_reg;
    logic                      trig_reg;
    logic                      fire;
    logic signed [DATA_W-1:0]  sig_q_reg;
    logic                      edge_prev_reg, src_prev_reg;
    logic [1:0]                sync_reg;
    logic                      ext_prev_reg;
    logic                      ext_rise;
    logic signed [EXT_W-1:0]   level_ext, hyst_ext, low_wide, high_wide;
    logic signed [DATA_W-1:0]  low_sat, high_sat, level_s;
    logic                      qualify, hit, sel_change;
    state_t                    post_state;

    // Register the incoming sample once.
    always_ff @(posedge clk) begin
        if (reset) sig_q_reg <= '0;
        else       sig_q_reg <= signed'(sig_in);
    end

    // Two-stage synchroniser for the asynchronous external trigger line.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            // Each stage samples the previous one (stage 0 samples the pin).
            always_ff @(posedge clk) begin
                if (reset) sync_reg[gi] <= 1'b0;
                else       sync_reg[gi] <= (gi == 0) ? ext_trig : sync_reg[(gi == 0) ? 0 : gi - 1];
            end
        end
    endgenerate

    // Delayed copies for the external edge detect and for mode-change detection.
    // During reset the mode copies track their inputs so release never looks like a change.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_prev_reg  <= 1'b0;
            edge_prev_reg <= edge_sel;
            src_prev_reg  <= src_sel;
        end else begin
            ext_prev_reg  <= sync_reg[1];
            edge_prev_reg <= edge_sel;
            src_prev_reg  <= src_sel;
        end
    end

    assign ext_rise = sync_reg[1] & ~ext_prev_reg;

    // Hysteresis thresholds, computed wide and clamped to the sample range.
    always_comb begin
        level_ext = {{2{level[DATA_W-1]}}, level};
        hyst_ext  = {2'b00, hyst};
        low_wide  = level_ext - hyst_ext;
        high_wide = level_ext + hyst_ext;
        level_s   = signed'(level);
        low_sat   = (low_wide  < SAT_MIN) ? SAT_MIN[DATA_W-1:0] : low_wide[DATA_W-1:0];
        high_sat  = (high_wide > SAT_MAX) ? SAT_MAX[DATA_W-1:0] : high_wide[DATA_W-1:0];
    end

    // Qualify (re-arm) and hit conditions for the selected source and polarity.
    always_comb begin
        qualify = 1'b0;
        hit     = 1'b0;
        if (src_sel) begin
            qualify = 1'b1;
            hit     = ext_rise;
        end else if (!edge_sel) begin
            qualify = (sig_q_reg <= low_sat);
            hit     = (sig_q_reg >= level_s);
        end else begin
            qualify = (sig_q_reg >= high_sat);
            hit     = (sig_q_reg <= level_s);
        end
    end

    // State and holdoff counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= single ? IDLE : QUALIFY;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    // Next-state logic; a mode change outside IDLE restarts qualification.
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        fire          = 1'b0;
        sel_change    = (edge_sel != edge_prev_reg) || (src_sel != src_prev_reg);
        post_state    = single ? IDLE : QUALIFY;
        case (state_reg)
            IDLE: begin
                if (arm || !single) state_next = QUALIFY;
            end
            QUALIFY: begin
                if (!sel_change && qualify) state_next = READY;
            end
            READY: begin
                if (sel_change) begin
                    state_next = QUALIFY;
                end else if (hit) begin
                    fire = 1'b1;
                    if (holdoff != '0) begin
                        state_next    = HOLDOFF;
                        hold_cnt_next = holdoff - CNT_W'(1);
                    end else begin
                        state_next = post_state;
                    end
                end
            end
            HOLDOFF: begin
                if (sel_change)                state_next = QUALIFY;
                else if (hold_cnt_reg == '0)   state_next = post_state;
                else                           hold_cnt_next = hold_cnt_reg - CNT_W'(1);
            end
            default: state_next = QUALIFY;
        endcase
    end

    // Registered trigger pulse and saturating trigger counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_reg  <= 1'b0;
            count_reg <= '0;
        end else begin
            trig_reg <= fire;
            if (cnt_clr)
                count_reg <= fire ? CNT_W'(1) : '0;
            else if (fire && count_reg != CNT_MAX)
                count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign trig_out   = trig_reg;
    assign trig_count = count_reg;
    assign armed      = (state_reg == QUALIFY) || (state_reg == READY);

endmodule

// File: tb/tb_seq_trigger_conditioner.sv
// Directed bench for seq_trigger_conditioner: level crossing, hysteresis,
// holdoff, single-shot arming, external source, counter clear/saturation,
// reset mid-holdoff and mode change in READY.
module tb_seq_trigger_conditioner;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sig_in;
    logic        ext_trig, src_sel, edge_sel, single, arm, cnt_clr;
    logic [15:0] level, hyst;
    logic [31:0] holdoff;
    logic        trig_out, armed;
    logic [31:0] trig_count;
    logic        sat_trig, sat_armed, sat_clr;
    logic [3:0]  sat_count;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int consec = 0;
    bit prev_trig = 1'b0;

    always #5 clk = ~clk;

    seq_trigger_conditioner dut (
        .clk(clk), .reset(reset), .sig_in(sig_in), .ext_trig(ext_trig),
        .src_sel(src_sel), .level(level), .hyst(hyst), .edge_sel(edge_sel),
        .single(single), .arm(arm), .holdoff(holdoff), .cnt_clr(cnt_clr),
        .trig_out(trig_out), .armed(armed), .trig_count(trig_count)
    );

    // Narrow-counter instance used only to reach counter saturation quickly.
    seq_trigger_conditioner #(.DATA_W(16), .CNT_W(4)) sat_dut (
        .clk(clk), .reset(reset), .sig_in(sig_in), .ext_trig(ext_trig),
        .src_sel(src_sel), .level(level), .hyst(hyst), .edge_sel(edge_sel),
        .single(single), .arm(arm), .holdoff(4'd0), .cnt_clr(sat_clr),
        .trig_out(sat_trig), .armed(sat_armed), .trig_count(sat_count)
    );

    // Pulse monitor: counts trig_out pulses and back-to-back pulses.
    always @(posedge clk) begin
        #1;
        if (trig_out === 1'b1) begin
            pulses++;
            if (prev_trig) consec++;
        end
        prev_trig = (trig_out === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic smp(input int v);
        sig_in = 16'(v);
        tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One-clock ext_trig pulse; returns trig_out three clocks after it, then idles 2 clocks.
    task automatic ext_pulse(output logic seen);
        ext_trig = 1'b1;
        tick();
        ext_trig = 1'b0;
        tick();
        tick();
        seen = trig_out;
        tick();
        tick();
    endtask

    initial begin
        int   prev_v, v, p0, n, last, min_gap, first;
        logic seen;

        reset = 1'b1; sig_in = '0; ext_trig = 1'b0; src_sel = 1'b0; edge_sel = 1'b0;
        single = 1'b0; arm = 1'b0; cnt_clr = 1'b0; sat_clr = 1'b0;
        level = 16'd1000; hyst = 16'd200; holdoff = 32'd0;

        // 1: rising ramps, auto-rearm, no holdoff
        do_reset();
        $display("T1 reset: trig_out=%0b trig_count=%0d armed=%0b", trig_out, trig_count, armed);
        chk("reset_trig", trig_out, 1'b0);
        chk("reset_count", trig_count, 32'd0);
        chk("reset_armed_auto", armed, 1'b1);
        p0 = pulses;
        prev_v = 0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i <= 40; i++) begin
                v = -2000 + 100 * i;
                smp(v);
                chk("ramp_trig_timing", trig_out, (prev_v == 1000) ? 1'b1 : 1'b0);
                prev_v = v;
            end
        end
        $display("T1 ramps: pulses=%0d trig_count=%0d", pulses - p0, trig_count);
        chk("ramp_pulses", 64'(pulses - p0), 64'd3);
        chk("ramp_count", trig_count, 32'd3);

        // 2: hysteresis
        smp(700);
        smp(1000);
        smp(900);
        chk("hyst_first_pulse", trig_out, 1'b1);
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            smp(1100);
            smp(900);
        end
        chk("hyst_no_retrigger", 64'(pulses - p0), 64'd0);
        smp(790);
        smp(900);
        smp(1000);
        chk("hyst_before_hit", trig_out, 1'b0);
        smp(900);
        chk("hyst_after_dip", trig_out, 1'b1);
        chk("hyst_count", trig_count, 32'd5);
        $display("T2 hysteresis: trig_count=%0d", trig_count);

        // 3: falling edge, holdoff=50, square wave +-500 period 20
        holdoff = 32'd50; edge_sel = 1'b1; level = 16'd0; hyst = 16'd10;
        n = 0; last = -1; min_gap = 1000000; first = -1;
        for (int k = 0; k < 200; k++) begin
            smp(((k % 20) < 10) ? 500 : -500);
            if (trig_out === 1'b1) begin
                n++;
                if (first < 0) first = k;
                if (last >= 0 && (k - last) < min_gap) min_gap = k - last;
                last = k;
            end
        end
        $display("T3 holdoff: pulses=%0d first=%0d min_gap=%0d", n, first, min_gap);
        chk("holdoff_pulses", 64'(n), 64'd4);
        chk("holdoff_first", 64'(first), 64'd11);
        chk("holdoff_min_gap", 64'(min_gap), 64'd60);
        chk("holdoff_count", trig_count, 32'd9);

        // 4: single-shot
        holdoff = 32'd0; edge_sel = 1'b0; level = 16'd1000; hyst = 16'd200;
        single = 1'b1; sig_in = '0;
        do_reset();
        chk("single_reset_armed", armed, 1'b0);
        chk("single_reset_count", trig_count, 32'd0);
        p0 = pulses;
        smp(0); smp(1200); smp(0); smp(1200); smp(1200);
        chk("single_no_arm_no_pulse", 64'(pulses - p0), 64'd0);
        chk("single_idle_armed", armed, 1'b0);
        arm = 1'b1;
        smp(0);
        arm = 1'b0;
        chk("single_armed_after_arm", armed, 1'b1);
        smp(0);
        smp(1200);
        smp(1200);
        chk("single_shot_pulse", trig_out, 1'b1);
        chk("single_disarmed", armed, 1'b0);
        p0 = pulses;
        smp(0); smp(1200);
        arm = 1'b1;
        smp(1200);
        arm = 1'b0;
        smp(1200); smp(1200); smp(1200);
        chk("arm_with_hit_no_pulse", 64'(pulses - p0), 64'd0);
        chk("arm_with_hit_armed", armed, 1'b1);
        smp(0); smp(1200); smp(1200);
        chk("rearm_pulse", trig_out, 1'b1);
        chk("single_count", trig_count, 32'd2);
        $display("T4 single-shot: trig_count=%0d armed=%0b", trig_count, armed);

        // 5: external source, counter clear, saturation
        single = 1'b0; src_sel = 1'b1; sig_in = '0;
        do_reset();
        tick();
        ext_trig = 1'b1;
        tick();
        ext_trig = 1'b0;
        chk("ext_lat_1", trig_out, 1'b0);
        tick();
        chk("ext_lat_2", trig_out, 1'b0);
        tick();
        chk("ext_lat_3", trig_out, 1'b1);
        tick(); tick();
        ext_trig = 1'b1;
        tick();
        ext_trig = 1'b0;
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_with_trig_pulse", trig_out, 1'b1);
        chk("clr_with_trig_count", trig_count, 32'd1);
        tick(); tick();
        for (int i = 0; i < 20; i++) begin
            ext_pulse(seen);
            chk("ext_pulse", seen, 1'b1);
            if (i == 11) chk("sat_below_max", sat_count, 4'd14);
        end
        chk("ext_count", trig_count, 32'd21);
        chk("sat_hold", sat_count, 4'hF);
        $display("T5 external: trig_count=%0d sat_count=%0d", trig_count, sat_count);

        // 6: reset mid-holdoff, then edge_sel toggled in READY
        holdoff = 32'd20;
        ext_pulse(seen);
        chk("pre_holdoff_pulse", seen, 1'b1);
        ext_pulse(seen);
        chk("holdoff_ignores_ext", seen, 1'b0);
        reset = 1'b1;
        tick();
        chk("midreset_trig", trig_out, 1'b0);
        chk("midreset_count", trig_count, 32'd0);
        chk("midreset_armed", armed, 1'b1);
        reset = 1'b0;
        tick();
        ext_pulse(seen);
        chk("holdoff_aborted", seen, 1'b1);
        holdoff = 32'd0; src_sel = 1'b0; level = 16'd1000; hyst = 16'd200;
        smp(0);
        smp(0);
        edge_sel = 1'b1;
        p0 = pulses;
        smp(500);
        chk("toggle_no_trig", trig_out, 1'b0);
        smp(500); smp(500); smp(500); smp(500);
        chk("toggle_no_pulses", 64'(pulses - p0), 64'd0);
        smp(1300);
        smp(500);
        smp(500);
        chk("toggle_requalified_pulse", trig_out, 1'b1);
        chk("no_consecutive_pulses", 64'(consec), 64'd0);
        $display("T6 reset/toggle: trig_count=%0d", trig_count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
